// File: rtl/sram_icb_ctrl_if.sv
// ---------------------------------------------------------------------------
// sram_icb_ctrl_if
//
// Purpose : ICB command/response channel bundle between a bus master and the
//           sram_icb_ctrl front end.
//
// Signals :
//   icb_cmd_valid / icb_cmd_ready   command handshake
//   icb_cmd_addr  [AW]              byte address
//   icb_cmd_read                    1 = read, 0 = write
//   icb_cmd_wdata [DW]              write data
//   icb_cmd_wmask [MW]              write byte enables
//   icb_rsp_valid / icb_rsp_ready   response handshake
//   icb_rsp_rdata [DW]              read data (0 for writes and errors)
//   icb_rsp_err                     address was out of range
//
// Modports: master (bus initiator), slave (sram_icb_ctrl).
// ---------------------------------------------------------------------------
interface sram_icb_ctrl_if #(
    parameter int AW = 32,
    parameter int DW = 32,
    parameter int MW = 4
);

    logic          icb_cmd_valid;
    logic          icb_cmd_ready;
    logic [AW-1:0] icb_cmd_addr;
    logic          icb_cmd_read;
    logic [DW-1:0] icb_cmd_wdata;
    logic [MW-1:0] icb_cmd_wmask;

    logic          icb_rsp_valid;
    logic          icb_rsp_ready;
    logic [DW-1:0] icb_rsp_rdata;
    logic          icb_rsp_err;

    modport master (
        output icb_cmd_valid,
        input  icb_cmd_ready,
        output icb_cmd_addr,
        output icb_cmd_read,
        output icb_cmd_wdata,
        output icb_cmd_wmask,
        input  icb_rsp_valid,
        output icb_rsp_ready,
        input  icb_rsp_rdata,
        input  icb_rsp_err
    );

    modport slave (
        input  icb_cmd_valid,
        output icb_cmd_ready,
        input  icb_cmd_addr,
        input  icb_cmd_read,
        input  icb_cmd_wdata,
        input  icb_cmd_wmask,
        output icb_rsp_valid,
        input  icb_rsp_ready,
        output icb_rsp_rdata,
        output icb_rsp_err
    );

endinterface

// File: rtl/sram_icb_ctrl.sv
// ---------------------------------------------------------------------------
// sram_icb_ctrl
//
// Purpose : Bus-side front end for the single-port sram_sim memory. Accepts
//           ICB commands, drives the SRAM pins combinationally in the fire
//           cycle, and returns one in-order response per command through a
//           2-entry response buffer. Absorbs the SRAM's one-cycle read
//           latency and response backpressure; out-of-range addresses are
//           answered with err=1 and never reach the array.
//
// Ports   :
//   clk       in   rising-edge clock
//   rst_n     in   asynchronous active-low reset
//   icb       slave modport of sram_icb_ctrl_if (command/response channels)
//   ram_cs    out  SRAM chip select
//   ram_we    out  SRAM write enable
//   ram_wem   out  SRAM byte write enables [MW]
//   ram_addr  out  SRAM byte address [AW] (passed through)
//   ram_din   out  SRAM write data [DW]
//   ram_dout  in   SRAM read data [DW], valid the cycle after a read fire
//
// Pipeline: cmd_fire in cycle N -> pend stage in N+1 (SRAM data arrives and
//           is captured into the FIFO) -> icb_rsp_valid in N+2.
// ---------------------------------------------------------------------------
module sram_icb_ctrl #(
    parameter int AW = 32,
    parameter int DW = 32,
    parameter int MW = 4,
    parameter int DP = 512
) (
    input  logic          clk,
    input  logic          rst_n,
    sram_icb_ctrl_if.slave icb,
    output logic          ram_cs,
    output logic          ram_we,
    output logic [MW-1:0] ram_wem,
    output logic [AW-1:0] ram_addr,
    output logic [DW-1:0] ram_din,
    input  logic [DW-1:0] ram_dout
);

    // First byte address past the end of the array.
    localparam logic [AW-1:0] ADDR_LIMIT = AW'(DP * MW);

    // ------------------------------------------------------------------
    // Handshake decode
    // ------------------------------------------------------------------
    logic cmd_fire;
    logic rsp_fire;
    logic in_range;

    assign cmd_fire = icb.icb_cmd_valid & icb.icb_cmd_ready;
    assign rsp_fire = icb.icb_rsp_valid & icb.icb_rsp_ready;
    assign in_range = (icb.icb_cmd_addr < ADDR_LIMIT);

    // ------------------------------------------------------------------
    // Inflight stage: one command between the fire edge and the edge at
    // which its response (and SRAM read data) is written to the FIFO.
    // ------------------------------------------------------------------
    logic pend_vld;
    logic pend_rd;
    logic pend_err;

    // NOTE: sequential state uses non-blocking (<=) so every register samples
    // the pre-edge values of its inputs regardless of process ordering.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pend_vld <= 1'b0;
            pend_rd  <= 1'b0;
            pend_err <= 1'b0;
        end else begin
            pend_vld <= cmd_fire;
            if (cmd_fire) begin
                pend_rd  <= icb.icb_cmd_read;
                pend_err <= ~in_range;
            end
        end
    end

    // ------------------------------------------------------------------
    // Response FIFO (2 entries)
    // ------------------------------------------------------------------
    logic          push;
    logic          pop;
    logic [DW-1:0] push_data;
    logic          wr_ptr;
    logic          rd_ptr;
    logic [1:0]    occ;
    logic [DW-1:0] fifo_data [2];
    logic          fifo_err  [2];

    assign push = pend_vld;
    assign pop  = rsp_fire;

    // ram_dout is only meaningful in the cycle right after a read fire, so
    // it is captured here and never looked at again; a following write to
    // the same word cannot disturb the buffered value.
    assign push_data = (pend_rd & ~pend_err) ? ram_dout : '0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
            occ    <= 2'd0;
        end else begin
            if (push) begin
                wr_ptr <= ~wr_ptr;
            end
            if (pop) begin
                rd_ptr <= ~rd_ptr;
            end
            // Simultaneous push and pop leaves occupancy unchanged.
            case ({push, pop})
                2'b10:   occ <= occ + 2'd1;
                2'b01:   occ <= occ - 2'd1;
                default: occ <= occ;
            endcase
        end
    end

    // NOTE: the storage array has no reset; nothing reads an entry before it
    // is written because the head output is gated by occupancy.
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_data[wr_ptr] <= push_data;
            fifo_err[wr_ptr]  <= pend_err;
        end
    end

    // ------------------------------------------------------------------
    // Response channel outputs
    // ------------------------------------------------------------------
    logic rsp_valid;

    assign rsp_valid = (occ != 2'd0);

    // NOTE: every output of a combinational block gets a default first so no
    // path through the block leaves it unassigned (which would infer a latch).
    always_comb begin
        icb.icb_rsp_valid = rsp_valid;
        icb.icb_rsp_rdata = '0;
        icb.icb_rsp_err   = 1'b0;
        if (rsp_valid) begin
            icb.icb_rsp_rdata = fifo_data[rd_ptr];
            icb.icb_rsp_err   = fifo_err[rd_ptr];
        end
    end

    // ------------------------------------------------------------------
    // Credit: accept only if the command will have a FIFO slot when its
    // response is pushed. A pop in this cycle frees a slot immediately, so
    // icb_rsp_ready feeds icb_cmd_ready combinationally on purpose.
    // occ >= 1 whenever rsp_fire is high, so the subtraction cannot wrap.
    // ------------------------------------------------------------------
    logic [2:0] outstanding;

    always_comb begin
        outstanding       = {1'b0, occ} + {2'b00, pend_vld} - {2'b00, rsp_fire};
        icb.icb_cmd_ready = rst_n & (outstanding < 3'd2);
    end

    // ------------------------------------------------------------------
    // SRAM drive. rst_n gates chip select so an asserted reset can never
    // touch the array, even with a command held valid.
    // ------------------------------------------------------------------
    always_comb begin
        ram_cs   = cmd_fire & in_range & rst_n;
        ram_we   = 1'b0;
        ram_wem  = '0;
        ram_addr = icb.icb_cmd_addr;
        ram_din  = icb.icb_cmd_wdata;
        if (ram_cs && !icb.icb_cmd_read) begin
            ram_we  = 1'b1;
            ram_wem = icb.icb_cmd_wmask;
        end
    end

endmodule

// File: tb/tb_sram_icb_ctrl.sv
// ---------------------------------------------------------------------------
// tb_sram_icb_ctrl
//
// Self-checking bench for sram_icb_ctrl with a behavioural single-port SRAM
// (write at the cs edge, registered read data). A negedge monitor keeps a
// scoreboard of expected responses built from a bench-owned memory image,
// checks response data/err, first-valid timing, credit (icb_cmd_ready) and
// SRAM pin drive. Scenario tasks add their own targeted checks.
// ---------------------------------------------------------------------------
module tb_sram_icb_ctrl;

    localparam int AW = 32;
    localparam int DW = 32;
    localparam int MW = 4;
    localparam int DP = 512;
    localparam int WB = $clog2(DP);

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    sram_icb_ctrl_if #(.AW(AW), .DW(DW), .MW(MW)) icb ();

    logic          ram_cs;
    logic          ram_we;
    logic [MW-1:0] ram_wem;
    logic [AW-1:0] ram_addr;
    logic [DW-1:0] ram_din;
    logic [DW-1:0] ram_dout;

    sram_icb_ctrl #(.AW(AW), .DW(DW), .MW(MW), .DP(DP)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .icb      (icb),
        .ram_cs   (ram_cs),
        .ram_we   (ram_we),
        .ram_wem  (ram_wem),
        .ram_addr (ram_addr),
        .ram_din  (ram_din),
        .ram_dout (ram_dout)
    );

    // ------------------------------------------------------------------
    // Behavioural SRAM
    // ------------------------------------------------------------------
    logic [DW-1:0] sram [DP];

    always @(posedge clk) begin
        if (ram_cs) begin
            if (ram_we) begin
                for (int b = 0; b < MW; b++) begin
                    if (ram_wem[b]) sram[ram_addr[WB+1:2]][8*b +: 8] <= ram_din[8*b +: 8];
                end
            end else begin
                ram_dout <= sram[ram_addr[WB+1:2]];
            end
        end
    end

    // ------------------------------------------------------------------
    // Scoreboard and monitor
    // ------------------------------------------------------------------
    typedef struct {
        logic [DW-1:0] data;
        logic          err;
        logic          rd;
        int            fire_cyc;
    } exp_t;

    exp_t          sb [$];
    logic [DW-1:0] ref_mem [DP];
    int            pop_cycles [$];
    logic [DW-1:0] rd_data_q [$];

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    int last_pop_cyc = -10;
    int pop_count = 0;
    int err_rsp_count = 0;
    logic head_seen = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin : monitor
        int            sz;
        int            exp_first;
        logic          rf;
        logic          cf;
        logic          exp_rdy;
        logic          in_rng;
        logic [AW-1:0] a;
        logic [DW-1:0] cur;
        exp_t          e;
        if (!rst_n) begin
            sb.delete();
            head_seen = 1'b0;
        end else begin
            sz = sb.size();
            rf = icb.icb_rsp_valid & icb.icb_rsp_ready;
            cf = icb.icb_cmd_valid & icb.icb_cmd_ready;

            exp_rdy = ((sz - (rf ? 1 : 0)) < 2);
            checks++;
            if (icb.icb_cmd_ready !== exp_rdy) begin
                failures++;
                $display("FAIL credit cyc=%0d got ready=%b want %b", cyc, icb.icb_cmd_ready, exp_rdy);
            end

            if (icb.icb_rsp_valid) begin
                if (sz == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL spurious_rsp cyc=%0d got valid=1 want 0", cyc);
                end else begin
                    if (!head_seen) begin
                        exp_first = (sb[0].fire_cyc + 2 > last_pop_cyc + 1) ? sb[0].fire_cyc + 2 : last_pop_cyc + 1;
                        checks++;
                        if (cyc != exp_first) begin
                            failures++;
                            $display("FAIL rsp_latency got cyc=%0d want cyc=%0d", cyc, exp_first);
                        end
                        head_seen = 1'b1;
                    end
                    if (rf) begin
                        e = sb.pop_front();
                        checks++;
                        if (icb.icb_rsp_rdata !== e.data || icb.icb_rsp_err !== e.err) begin
                            failures++;
                            $display("FAIL rsp_data cyc=%0d got rdata=%h err=%b want rdata=%h err=%b",
                                     cyc, icb.icb_rsp_rdata, icb.icb_rsp_err, e.data, e.err);
                        end
                        last_pop_cyc = cyc;
                        head_seen = 1'b0;
                        pop_count++;
                        pop_cycles.push_back(cyc);
                        if (e.rd && !e.err) rd_data_q.push_back(icb.icb_rsp_rdata);
                        if (icb.icb_rsp_err) err_rsp_count++;
                    end
                end
            end else begin
                checks++;
                if (icb.icb_rsp_rdata !== '0 || icb.icb_rsp_err !== 1'b0) begin
                    failures++;
                    $display("FAIL idle_rsp cyc=%0d got rdata=%h err=%b want 0/0", cyc, icb.icb_rsp_rdata, icb.icb_rsp_err);
                end
            end

            if (cf) begin
                a = icb.icb_cmd_addr;
                in_rng = (a < AW'(DP * MW));
                checks++;
                if (ram_cs !== in_rng) begin
                    failures++;
                    $display("FAIL ram_cs addr=%h got %b want %b", a, ram_cs, in_rng);
                end
                if (in_rng) begin
                    checks++;
                    if (ram_we !== !icb.icb_cmd_read || ram_wem !== (icb.icb_cmd_read ? '0 : icb.icb_cmd_wmask) ||
                        ram_addr !== a || ram_din !== icb.icb_cmd_wdata) begin
                        failures++;
                        $display("FAIL ram_pins addr=%h got we=%b wem=%h a=%h d=%h", a, ram_we, ram_wem, ram_addr, ram_din);
                    end
                end
                e.rd = icb.icb_cmd_read;
                e.err = !in_rng;
                e.fire_cyc = cyc;
                e.data = '0;
                if (in_rng) begin
                    if (icb.icb_cmd_read) begin
                        e.data = ref_mem[a[WB+1:2]];
                    end else begin
                        cur = ref_mem[a[WB+1:2]];
                        for (int b = 0; b < MW; b++) begin
                            if (icb.icb_cmd_wmask[b]) cur[8*b +: 8] = icb.icb_cmd_wdata[8*b +: 8];
                        end
                        ref_mem[a[WB+1:2]] = cur;
                    end
                end
                sb.push_back(e);
            end else begin
                checks++;
                if (ram_cs !== 1'b0) begin
                    failures++;
                    $display("FAIL ram_cs_idle cyc=%0d got 1 want 0", cyc);
                end
            end

            checks++;
            if (sb.size() > 2) begin
                failures++;
                $display("FAIL overflow cyc=%0d got outstanding=%0d want <=2", cyc, sb.size());
            end
        end
    end

    // ------------------------------------------------------------------
    // Drivers
    // ------------------------------------------------------------------
    task automatic drive(input logic [AW-1:0] a, input logic rd, input logic [DW-1:0] wd, input logic [MW-1:0] wm);
        icb.icb_cmd_valid = 1'b1;
        icb.icb_cmd_addr  = a;
        icb.icb_cmd_read  = rd;
        icb.icb_cmd_wdata = wd;
        icb.icb_cmd_wmask = wm;
    endtask

    // Offer a command and return after the edge at which it fired.
    task automatic issue(input logic [AW-1:0] a, input logic rd, input logic [DW-1:0] wd,
                         input logic [MW-1:0] wm, output int waits);
        drive(a, rd, wd, wm);
        waits = 0;
        forever begin
            @(negedge clk);
            if (icb.icb_cmd_ready) break;
            waits++;
            if (waits > 50) begin
                checks++;
                failures++;
                $display("FAIL issue_timeout addr=%h got ready=0 want 1 within 50 cycles", a);
                break;
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        icb.icb_cmd_valid = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (sb.size() != 0 && n < 100) begin
            @(negedge clk);
            #1;
            n++;
        end
        checks++;
        if (sb.size() != 0) begin
            failures++;
            $display("FAIL drain_timeout got outstanding=%0d want 0", sb.size());
        end
        @(posedge clk);
        #1;
    endtask

    task automatic check_outputs_zero(input string tag);
        checks++;
        if (icb.icb_cmd_ready !== 1'b0 || icb.icb_rsp_valid !== 1'b0 || icb.icb_rsp_rdata !== '0 ||
            icb.icb_rsp_err !== 1'b0 || ram_cs !== 1'b0 || ram_we !== 1'b0 || ram_wem !== '0) begin
            failures++;
            $display("FAIL %s got rdy=%b vld=%b rdata=%h err=%b cs=%b we=%b wem=%h want all 0", tag,
                     icb.icb_cmd_ready, icb.icb_rsp_valid, icb.icb_rsp_rdata, icb.icb_rsp_err, ram_cs, ram_we, ram_wem);
        end
    endtask

    // ------------------------------------------------------------------
    // Scenarios
    // ------------------------------------------------------------------
    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_outputs_zero("reset_outputs");
        rst_n = 1'b1;
        #1;
        checks++;
        if (icb.icb_cmd_ready !== 1'b1) begin
            failures++;
            $display("FAIL reset_release_ready got %b want 1", icb.icb_cmd_ready);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_write_merge();
        int w;
        icb.icb_rsp_ready = 1'b1;
        rd_data_q.delete();
        issue(32'h10, 1'b0, 32'hDEADBEEF, 4'hF, w);
        issue(32'h10, 1'b0, 32'h00000055, 4'h1, w);
        issue(32'h10, 1'b1, '0, '0, w);
        idle();
        drain();
        checks++;
        if (rd_data_q.size() != 1 || rd_data_q[0] !== 32'hDEADBE55) begin
            failures++;
            $display("FAIL write_merge got n=%0d rdata=%h want 1 x DEADBE55", rd_data_q.size(),
                     (rd_data_q.size() > 0) ? rd_data_q[0] : 32'h0);
        end
    endtask

    task automatic test_back_to_back();
        int w;
        int stalls;
        int p0;
        icb.icb_rsp_ready = 1'b1;
        for (int i = 0; i < 8; i++) issue(AW'(4 * i), 1'b0, 32'hA500_0000 + DW'(i * 32'h0101), 4'hF, w);
        idle();
        drain();
        pop_cycles.delete();
        rd_data_q.delete();
        p0 = pop_count;
        stalls = 0;
        for (int i = 0; i < 8; i++) begin
            issue(AW'(4 * i), 1'b1, '0, '0, w);
            stalls += w;
        end
        idle();
        drain();
        checks++;
        if (stalls != 0) begin
            failures++;
            $display("FAIL b2b_ready got stalls=%0d want 0", stalls);
        end
        checks++;
        if (pop_count - p0 != 8 || pop_cycles.size() != 8 || pop_cycles[7] - pop_cycles[0] != 7) begin
            failures++;
            $display("FAIL b2b_rsp_spacing got pops=%0d span=%0d want 8/7", pop_count - p0,
                     (pop_cycles.size() == 8) ? pop_cycles[7] - pop_cycles[0] : -1);
        end
        checks++;
        if (rd_data_q.size() != 8 || rd_data_q[3] !== 32'hA500_0303) begin
            failures++;
            $display("FAIL b2b_word3 got %h want a5000303", (rd_data_q.size() > 3) ? rd_data_q[3] : 32'h0);
        end
    endtask

    task automatic test_backpressure();
        int idx;
        idx = 0;
        icb.icb_rsp_ready = 1'b0;
        drive(32'h0, 1'b1, '0, '0);
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            if (icb.icb_cmd_ready) idx++;
            @(posedge clk);
            #1;
            if (idx < 4) drive(AW'(4 * idx), 1'b1, '0, '0);
            else idle();
        end
        checks++;
        if (idx != 2 || icb.icb_cmd_ready !== 1'b0) begin
            failures++;
            $display("FAIL bp_accept got accepted=%0d ready=%b want 2/0", idx, icb.icb_cmd_ready);
        end
        icb.icb_rsp_ready = 1'b1;
        for (int c = 0; c < 20 && idx < 4; c++) begin
            @(negedge clk);
            if (icb.icb_cmd_ready) idx++;
            @(posedge clk);
            #1;
            if (idx < 4) drive(AW'(4 * idx), 1'b1, '0, '0);
            else idle();
        end
        idle();
        checks++;
        if (idx != 4) begin
            failures++;
            $display("FAIL bp_release got accepted=%0d want 4", idx);
        end
        drain();
    endtask

    task automatic test_boundary();
        int w;
        int e0;
        icb.icb_rsp_ready = 1'b1;
        rd_data_q.delete();
        e0 = err_rsp_count;
        issue(32'h800, 1'b1, '0, '0, w);
        issue(32'h7FC, 1'b0, 32'h12345678, 4'hF, w);
        issue(32'h7FC, 1'b1, '0, '0, w);
        issue(32'h800, 1'b0, 32'hFFFFFFFF, 4'hF, w);
        issue(32'hFFFF_FFFC, 1'b1, '0, '0, w);
        idle();
        drain();
        checks++;
        if (err_rsp_count - e0 != 3) begin
            failures++;
            $display("FAIL boundary_err got errs=%0d want 3", err_rsp_count - e0);
        end
        checks++;
        if (rd_data_q.size() != 1 || rd_data_q[0] !== 32'h12345678) begin
            failures++;
            $display("FAIL boundary_7fc got %h want 12345678", (rd_data_q.size() > 0) ? rd_data_q[0] : 32'h0);
        end
    endtask

    task automatic test_read_capture();
        int w;
        icb.icb_rsp_ready = 1'b1;
        issue(32'h20, 1'b0, 32'h11111111, 4'hF, w);
        idle();
        drain();
        rd_data_q.delete();
        issue(32'h20, 1'b1, '0, '0, w);
        issue(32'h20, 1'b0, 32'h22222222, 4'hF, w);
        issue(32'h20, 1'b1, '0, '0, w);
        idle();
        drain();
        checks++;
        if (rd_data_q.size() != 2 || rd_data_q[0] !== 32'h11111111 || rd_data_q[1] !== 32'h22222222) begin
            failures++;
            $display("FAIL read_capture got n=%0d first=%h want 2: 11111111,22222222", rd_data_q.size(),
                     (rd_data_q.size() > 0) ? rd_data_q[0] : 32'h0);
        end
    endtask

    task automatic test_reset_midop();
        int w;
        int stray;
        icb.icb_rsp_ready = 1'b0;
        issue(32'h40, 1'b0, 32'hCAFE0001, 4'hF, w);
        issue(32'h44, 1'b0, 32'hCAFE0002, 4'hF, w);
        // One response buffered, one inflight, a third command held valid.
        drive(32'h40, 1'b1, '0, '0);
        #2;
        rst_n = 1'b0;
        #1;
        check_outputs_zero("midop_reset_outputs");
        idle();
        icb.icb_rsp_ready = 1'b1;
        @(posedge clk);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        #1;
        checks++;
        if (icb.icb_cmd_ready !== 1'b1) begin
            failures++;
            $display("FAIL midop_ready got %b want 1", icb.icb_cmd_ready);
        end
        stray = 0;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            if (icb.icb_rsp_valid) stray++;
        end
        checks++;
        if (stray != 0) begin
            failures++;
            $display("FAIL midop_stale_rsp got %0d valid cycles want 0", stray);
        end
        @(posedge clk);
        #1;
        issue(32'h44, 1'b1, '0, '0, w);
        idle();
        drain();
    endtask

    // ------------------------------------------------------------------
    // Sequence
    // ------------------------------------------------------------------
    initial begin
        icb.icb_cmd_valid = 1'b0;
        icb.icb_cmd_addr  = '0;
        icb.icb_cmd_read  = 1'b0;
        icb.icb_cmd_wdata = '0;
        icb.icb_cmd_wmask = '0;
        icb.icb_rsp_ready = 1'b0;

        test_reset();
        test_write_merge();
        test_back_to_back();
        test_backpressure();
        test_boundary();
        test_read_capture();
        test_reset_midop();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
